// File: rtl/tone_note_detector.sv
// ---------------------------------------------------------------------------
// tone_note_detector
//
// Receive-side partner of the square-wave tone generators. It measures the
// period of one incoming tone line in clock cycles and decodes it back to one
// of the eight piano keys (C, D, E, F, G, A, B, C2). A key is reported only
// after LOCK_CNT consecutive periods have fallen in the same key window.
//
// Parameters
//   TOL         +/- window in clk cycles around each nominal period
//   LOCK_CNT    consecutive identical classifications needed to lock (1..7)
//   MAX_PERIOD  periods longer than this are treated as silence
//   NOMINAL     nominal period of each key, index 0 = C .. index 7 = C2
//
// Ports
//   i_clk          system clock (25 MHz, same clock as the tone generators)
//   i_rst_n        asynchronous active-low reset
//   i_tone_in      square-wave tone, asynchronous to i_clk
//   o_note_onehot  decoded key, one-hot, bit0 = C .. bit7 = C2; 0 when unlocked
//   o_note_idx     decoded key index 0..7; 0 when unlocked
//   o_note_valid   high while a key is locked
//   o_note_strobe  one-cycle pulse when a lock is (re)acquired
//   o_period       last measured period, MAX_PERIOD+1 after a silence timeout
// ---------------------------------------------------------------------------
module tone_note_detector #(
  parameter int TOL        = 1000,
  parameter int LOCK_CNT   = 3,
  parameter int MAX_PERIOD = 100000,
  parameter logic [7:0][16:0] NOMINAL = {17'd47775, 17'd50619, 17'd56819, 17'd63777,
                                         17'd71593, 17'd75851, 17'd85122, 17'd95567}
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_tone_in,
  output logic [7:0]  o_note_onehot,
  output logic [2:0]  o_note_idx,
  output logic        o_note_valid,
  output logic        o_note_strobe,
  output logic [16:0] o_period
);

  // Counter value that means "no edge seen for longer than any legal period".
  localparam logic [16:0] SAT_COUNT  = 17'(MAX_PERIOD + 1);
  localparam logic [17:0] TOL_W      = 18'(TOL);
  localparam logic [2:0]  LOCK_W     = 3'(LOCK_CNT);
  // Classification result when the period falls in no key window.
  localparam logic [3:0]  CLASS_NONE = 4'd8;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ARMED  = 2'd1,
    S_LOCKED = 2'd2
  } state_t;

  // Input conditioning
  logic        r_sync1;
  logic        r_sync2;
  logic        r_sync3;
  logic        r_edge;

  // Period measurement
  logic [16:0] r_count;
  logic [17:0] w_countExt;
  logic        w_timeout;

  // Classification
  logic [3:0]  w_class;
  logic [2:0]  w_nextMatch;
  logic [7:0]  w_classOnehot;

  // Lock tracking and registered outputs
  state_t      r_state;
  logic [3:0]  r_prevClass;
  logic [2:0]  r_match;
  logic [7:0]  r_onehot;
  logic [2:0]  r_idx;
  logic        r_valid;
  logic        r_strobe;
  logic [16:0] r_period;

  // Two flops bring the asynchronous tone into the clock domain; the third
  // holds the previous synchronized level so a rising edge can be seen.
  // The edge flag is itself registered, so it rises three clocks after the
  // tone edge and is exactly one clock wide. A pulse shorter than a clock
  // may be missed, but one input edge can never produce two flags.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_sync3 <= 1'b0;
      r_edge  <= 1'b0;
    end else begin
      r_sync1 <= i_tone_in;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
      r_edge  <= r_sync2 & ~r_sync3;
    end
  end

  // Period counter. It restarts at 1 on the edge cycle, so the value it holds
  // during the next edge cycle is the distance between the two edges in
  // clocks. It sticks at SAT_COUNT so a silent line cannot wrap around and
  // alias into a legal period.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (r_edge) begin
      r_count <= 17'd1;
    end else if (r_count != SAT_COUNT) begin
      r_count <= r_count + 17'd1;
    end
  end

  assign w_timeout  = (r_count == SAT_COUNT);
  assign w_countExt = {1'b0, r_count};

  // Compare the running count against every key window. The windows are far
  // enough apart that at most one key can match, so the loop order does not
  // matter. One extra bit keeps nominal+TOL from overflowing.
  always_comb begin
    w_class = CLASS_NONE;
    for (int k = 0; k < 8; k++) begin
      if ((w_countExt + TOL_W >= {1'b0, NOMINAL[k]}) &&
          (w_countExt <= {1'b0, NOMINAL[k]} + TOL_W)) begin
        w_class = 4'(k);
      end
    end
  end

  // Run length the match counter would take if this edge's class is a real
  // key: a repeat extends the run (capped at LOCK_CNT), a new key starts a
  // fresh run of one.
  always_comb begin
    if (w_class != r_prevClass) begin
      w_nextMatch = 3'd1;
    end else if (r_match < LOCK_W) begin
      w_nextMatch = r_match + 3'd1;
    end else begin
      w_nextMatch = r_match;
    end
  end

  assign w_classOnehot = 8'b1 << w_class[2:0];

  // Lock state machine with all outputs registered. A silence timeout has
  // priority over everything, including an edge landing on the same cycle;
  // such an edge simply becomes the first reference edge of a new
  // measurement. The first edge after IDLE only starts the counter, because
  // the count it ends is not a real period. Any loss of lock clears the key
  // outputs together with o_note_valid, and the strobe fires only on entry to
  // LOCKED.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_prevClass <= CLASS_NONE;
      r_match     <= '0;
      r_onehot    <= '0;
      r_idx       <= '0;
      r_valid     <= 1'b0;
      r_strobe    <= 1'b0;
      r_period    <= '0;
    end else begin
      r_strobe <= 1'b0;
      if (w_timeout) begin
        r_state     <= r_edge ? S_ARMED : S_IDLE;
        r_prevClass <= CLASS_NONE;
        r_match     <= '0;
        r_onehot    <= '0;
        r_idx       <= '0;
        r_valid     <= 1'b0;
        r_period    <= SAT_COUNT;
      end else if (r_edge) begin
        r_period <= r_count;
        case (r_state)
          S_IDLE: begin
            r_state     <= S_ARMED;
            r_prevClass <= CLASS_NONE;
            r_match     <= '0;
          end
          S_ARMED: begin
            if (w_class == CLASS_NONE) begin
              r_prevClass <= CLASS_NONE;
              r_match     <= '0;
            end else begin
              r_prevClass <= w_class;
              r_match     <= w_nextMatch;
              if (w_nextMatch >= LOCK_W) begin
                r_state  <= S_LOCKED;
                r_valid  <= 1'b1;
                r_onehot <= w_classOnehot;
                r_idx    <= w_class[2:0];
                r_strobe <= 1'b1;
              end
            end
          end
          S_LOCKED: begin
            if (w_class != r_prevClass) begin
              r_state     <= S_ARMED;
              r_valid     <= 1'b0;
              r_onehot    <= '0;
              r_idx       <= '0;
              r_prevClass <= w_class;
              r_match     <= (w_class == CLASS_NONE) ? 3'd0 : 3'd1;
            end
          end
          default: begin
            r_state     <= S_IDLE;
            r_prevClass <= CLASS_NONE;
            r_match     <= '0;
            r_onehot    <= '0;
            r_idx       <= '0;
            r_valid     <= 1'b0;
          end
        endcase
      end
    end
  end

  assign o_note_onehot = r_onehot;
  assign o_note_idx    = r_idx;
  assign o_note_valid  = r_valid;
  assign o_note_strobe = r_strobe;
  assign o_period      = r_period;

endmodule

// File: tb/tb_tone_note_detector.sv
// ---------------------------------------------------------------------------
// tb_tone_note_detector
//
// Drives square-wave tones with chosen rise-to-rise periods into
// tone_note_detector and compares its outputs with a reference model that
// works purely on the sequence of rising-edge times: periods are classified
// by distance to each nominal value, and a key is locked once the run of
// identical classifications since the line was last silent reaches LOCK_CNT.
// Nominal periods are scaled down so a full run stays short.
// ---------------------------------------------------------------------------
module tb_tone_note_detector;

  localparam int TOL        = 10;
  localparam int LOCK_CNT   = 3;
  localparam int MAX_PERIOD = 1000;
  localparam int NONE       = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        tone;
  logic [7:0]  o_note_onehot;
  logic [2:0]  o_note_idx;
  logic        o_note_valid;
  logic        o_note_strobe;
  logic [16:0] o_period;

  // Key periods in clocks, index 0 = C .. 7 = C2.
  int nom [8] = '{956, 851, 759, 716, 638, 568, 506, 478};

  // Bookkeeping
  int errors = 0;
  int checks = 0;
  int now = 0;
  int strobeSeen = 0;

  // Reference model state
  int lastRise = 0;
  bit armed = 1'b0;
  int runLen = 0;
  int runClass = NONE;
  bit expValid = 1'b0;
  int expPeriod = 0;
  int expStrobes = 0;

  tone_note_detector #(
    .TOL(TOL),
    .LOCK_CNT(LOCK_CNT),
    .MAX_PERIOD(MAX_PERIOD),
    .NOMINAL({17'd478, 17'd506, 17'd568, 17'd638, 17'd716, 17'd759, 17'd851, 17'd956})
  ) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .i_tone_in(tone),
    .o_note_onehot(o_note_onehot),
    .o_note_idx(o_note_idx),
    .o_note_valid(o_note_valid),
    .o_note_strobe(o_note_strobe),
    .o_period(o_period)
  );

  always #5 clk = ~clk;

  // Count every clock cycle during which the strobe is high.
  always @(negedge clk) begin
    if (o_note_strobe === 1'b1) strobeSeen <= strobeSeen + 1;
  end

  task automatic waitNeg(input int n);
    if (n > 0) begin
      repeat (n) @(negedge clk);
      now += n;
    end
  endtask

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int classify(input int p);
    for (int k = 0; k < 8; k++) begin
      if ((p - nom[k] <= TOL) && (nom[k] - p <= TOL)) return k;
    end
    return NONE;
  endfunction

  task automatic resetModel();
    lastRise  = now - 3;
    armed     = 1'b0;
    runLen    = 0;
    runClass  = NONE;
    expValid  = 1'b0;
    expPeriod = 0;
  endtask

  // Update the model for a rising edge driven at the current negedge.
  task automatic modelEdge();
    int gap;
    int cls;
    bit newValid;
    gap = now - lastRise;
    lastRise = now;
    if (!armed || gap > MAX_PERIOD) begin
      armed     = 1'b1;
      runLen    = 0;
      runClass  = NONE;
      expPeriod = (gap > MAX_PERIOD) ? MAX_PERIOD + 1 : gap;
    end else begin
      expPeriod = gap;
      cls = classify(gap);
      if (cls == NONE) begin
        runLen   = 0;
        runClass = NONE;
      end else if (cls == runClass) begin
        if (runLen < LOCK_CNT) runLen++;
      end else begin
        runClass = cls;
        runLen   = 1;
      end
    end
    newValid = (runLen >= LOCK_CNT);
    if (newValid && !expValid) expStrobes++;
    expValid = newValid;
  endtask

  task automatic checkOutput(input string tag);
    #1;
    // Silence: the line has been quiet long enough for the counter to saturate.
    if (now >= lastRise + MAX_PERIOD + 5) begin
      armed     = 1'b0;
      runLen    = 0;
      runClass  = NONE;
      expValid  = 1'b0;
      expPeriod = MAX_PERIOD + 1;
    end
    checkVal({tag, ".valid"},  32'(o_note_valid),  32'(expValid));
    checkVal({tag, ".onehot"}, 32'(o_note_onehot), expValid ? (32'd1 << runClass) : 32'd0);
    checkVal({tag, ".idx"},    32'(o_note_idx),    expValid ? 32'(runClass) : 32'd0);
    checkVal({tag, ".period"}, 32'(o_period),      32'(expPeriod));
    checkVal({tag, ".strobes"}, 32'(strobeSeen),   32'(expStrobes));
  endtask

  // One tone period: fall halfway, rise `gap` clocks after the previous rise,
  // then check the outputs four clocks after the new rise.
  task automatic applyStimulus(input int gap, input string tag);
    waitNeg(lastRise + gap / 2 - now);
    tone = 1'b0;
    waitNeg(lastRise + gap - now);
    tone = 1'b1;
    modelEdge();
    waitNeg(4);
    checkOutput(tag);
  endtask

  initial begin
    int note;
    int reps;
    int gap;

    rst_n = 1'b0;
    tone  = 1'b0;
    waitNeg(2);
    checkOutput("reset");
    waitNeg(1);
    rst_n = 1'b1;
    resetModel();

    $display("[TB] lock on A");
    for (int i = 0; i < 4; i++) applyStimulus(nom[5], "lockA");
    checkVal("lockA.valid_c",  32'(o_note_valid),  32'd1);
    checkVal("lockA.onehot_c", 32'(o_note_onehot), 32'b0010_0000);
    checkVal("lockA.idx_c",    32'(o_note_idx),    32'd5);
    checkVal("lockA.period_c", 32'(o_period),      32'd568);
    checkVal("lockA.strobe_c", 32'(strobeSeen),    32'd1);

    $display("[TB] reset while locked");
    waitNeg(lastRise + nom[5] / 2 - now);
    tone  = 1'b0;
    rst_n = 1'b0;
    #1;
    checkVal("rstMid.valid",  32'(o_note_valid),  32'd0);
    checkVal("rstMid.onehot", 32'(o_note_onehot), 32'd0);
    checkVal("rstMid.idx",    32'(o_note_idx),    32'd0);
    checkVal("rstMid.strobe", 32'(o_note_strobe), 32'd0);
    checkVal("rstMid.period", 32'(o_period),      32'd0);
    waitNeg(1);
    rst_n = 1'b1;
    resetModel();

    $display("[TB] C then C2");
    for (int i = 0; i < 4; i++) applyStimulus(nom[0], "lockC");
    checkVal("lockC.strobe_c", 32'(strobeSeen), 32'd2);
    applyStimulus(nom[7], "dropC2");
    checkVal("dropC2.valid_c", 32'(o_note_valid), 32'd0);
    for (int i = 0; i < 2; i++) applyStimulus(nom[7], "lockC2");
    checkVal("lockC2.valid_c",  32'(o_note_valid),  32'd1);
    checkVal("lockC2.onehot_c", 32'(o_note_onehot), 32'b1000_0000);
    checkVal("lockC2.strobe_c", 32'(strobeSeen),    32'd3);

    $display("[TB] window edges");
    for (int i = 0; i < 3; i++) applyStimulus(nom[6] + TOL, "bEdgeIn");
    checkVal("bEdgeIn.idx_c", 32'(o_note_idx), 32'd6);
    for (int i = 0; i < 5; i++) applyStimulus(nom[6] + TOL + 1, "bEdgeOut");
    checkVal("bEdgeOut.valid_c",  32'(o_note_valid), 32'd0);
    checkVal("bEdgeOut.strobe_c", 32'(strobeSeen),   32'd4);

    $display("[TB] alternating G/A");
    for (int i = 0; i < 8; i++) applyStimulus((i % 2 == 0) ? nom[4] : nom[5], "altGA");
    checkVal("altGA.valid_c", 32'(o_note_valid), 32'd0);

    $display("[TB] silence after lock on E");
    for (int i = 0; i < 3; i++) applyStimulus(nom[2], "lockE");
    checkVal("lockE.strobe_c", 32'(strobeSeen), 32'd5);
    waitNeg(lastRise + nom[2] / 2 - now);
    tone = 1'b0;
    waitNeg(lastRise + MAX_PERIOD + 4 - now);
    #1;
    checkVal("silence.before", 32'(o_note_valid), 32'd1);
    waitNeg(1);
    #1;
    checkVal("silence.valid",  32'(o_note_valid), 32'd0);
    checkVal("silence.period", 32'(o_period),     32'(MAX_PERIOD + 1));
    checkOutput("silence");

    $display("[TB] edge coincident with saturation");
    applyStimulus(MAX_PERIOD + 50, "restart");
    for (int i = 0; i < 3; i++) applyStimulus(nom[2], "relockE");
    applyStimulus(MAX_PERIOD + 1, "coincident");
    checkVal("coincident.valid_c",  32'(o_note_valid), 32'd0);
    checkVal("coincident.period_c", 32'(o_period),     32'(MAX_PERIOD + 1));
    for (int i = 0; i < 3; i++) applyStimulus(nom[2], "afterCoin");

    $display("[TB] random note bursts");
    for (int b = 0; b < 12; b++) begin
      note = int'($urandom_range(0, 7));
      reps = int'($urandom_range(1, 5));
      for (int r = 0; r < reps; r++) begin
        gap = nom[note] + int'($urandom_range(0, 2 * TOL + 4)) - (TOL + 2);
        applyStimulus(gap, "random");
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
